tlu_dut_rx: RTL

- DUT-side end of the TLU trigger/busy handshake, the counterpart of the master's per-DUT transmit channel.
- Detects a trigger on TLU_TRIGGER and raises TLU_BUSY.
- In data-handshake mode, generates TLU_CLOCK and shifts in the trigger number serially from TLU_TRIGGER.
- Presents trigger ID plus latched timestamp to DUT readout logic as a one-cycle valid pulse, and holds busy until the DUT reports ready.

---
 rtl/tlu_dut_rx.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/tlu_dut_rx.sv
// DUT-side receiver of the TLU trigger/busy handshake: detects triggers, raises busy,
// optionally clocks in the trigger number, and hands ID + timestamp to readout.
module tlu_dut_rx #(
    parameter int TRIG_ID_WIDTH = 15,
    parameter int TS_WIDTH      = 32
) (
    input  logic                     SYS_CLK,
    input  logic                     SYS_RST_N,
    input  logic                     EN,
    input  logic                     CONF_DATA_MODE,
    input  logic [7:0]               CONF_HALF_PERIOD,
    input  logic                     DUT_READY,
    input  logic                     TLU_TRIGGER,
    input  logic                     TLU_RESET,
    output logic                     TLU_BUSY,
    output logic                     TLU_CLOCK,
    output logic [TRIG_ID_WIDTH-1:0] TRIG_ID,
    output logic [TS_WIDTH-1:0]      TRIG_TIMESTAMP,
    output logic                     TRIG_VALID,
    output logic                     RESET_PULSE,
    output logic [7:0]               SKIP_CNT
);

    localparam int BW = (TRIG_ID_WIDTH > 1) ? $clog2(TRIG_ID_WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE,
        BUSY_WAIT,
        SHIFT,
        DONE,
        HOLD
    } state_t;

    state_t                   state_q;
    logic                     trig_meta_q, trig_s_q, trig_s_dly_q;
    logic                     rst_meta_q, rst_s_q, rst_s_dly_q;
    logic                     trig_edge, rst_edge;
    logic [TS_WIDTH-1:0]      ts_q, ts_hold_q, ts_out_q, ts_cap;
    logic [TRIG_ID_WIDTH-1:0] sr_q, id_q, id_cnt_q;
    logic [7:0]               skip_q, h_q, half_sel;
    logic [8:0]               cnt_q;
    logic [BW-1:0]            bit_q;
    logic                     busy_q, clk_q, valid_q, reset_pulse_q;
    logic                     last_high, last_low;

    // Synchronisers preset to 1 so a line already high at reset release is not an edge.
    always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
            trig_meta_q  <= 1'b1;
            trig_s_q     <= 1'b1;
            trig_s_dly_q <= 1'b1;
            rst_meta_q   <= 1'b1;
            rst_s_q      <= 1'b1;
            rst_s_dly_q  <= 1'b1;
        end else begin
            trig_meta_q  <= TLU_TRIGGER;
            trig_s_q     <= trig_meta_q;
            trig_s_dly_q <= trig_s_q;
            rst_meta_q   <= TLU_RESET;
            rst_s_q      <= rst_meta_q;
            rst_s_dly_q  <= rst_s_q;
        end
    end

    assign trig_edge = trig_s_q & ~trig_s_dly_q;
    assign rst_edge  = rst_s_q & ~rst_s_dly_q;
    assign ts_cap    = rst_edge ? '0 : ts_q;
    assign half_sel  = (CONF_HALF_PERIOD < 8'd8) ? 8'd8 : CONF_HALF_PERIOD;
    assign last_high = (cnt_q == ({1'b0, h_q} - 9'd1));
    assign last_low  = (cnt_q == ({h_q, 1'b0} - 9'd1));

    always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
            ts_q          <= '0;
            skip_q        <= '0;
            reset_pulse_q <= 1'b0;
        end else begin
            reset_pulse_q <= rst_edge;
            ts_q          <= rst_edge ? '0 : ts_q + 1'b1;
            if (rst_edge)
                skip_q <= '0;
            else if (trig_edge && state_q != IDLE && skip_q != 8'hFF)
                skip_q <= skip_q + 8'd1;
        end
    end

    always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            clk_q     <= 1'b0;
            valid_q   <= 1'b0;
            id_q      <= '0;
            ts_out_q  <= '0;
            ts_hold_q <= '0;
            sr_q      <= '0;
            id_cnt_q  <= '0;
            h_q       <= 8'd8;
            cnt_q     <= '0;
            bit_q     <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (trig_edge && EN) begin
                        busy_q    <= 1'b1;
                        ts_hold_q <= ts_cap;
                        h_q       <= half_sel;
                        cnt_q     <= '0;
                        bit_q     <= '0;
                        if (CONF_DATA_MODE) begin
                            state_q <= BUSY_WAIT;
                        end else begin
                            state_q  <= DONE;
                            valid_q  <= 1'b1;
                            id_q     <= id_cnt_q;
                            ts_out_q <= ts_cap;
                            id_cnt_q <= id_cnt_q + 1'b1;
                        end
                    end
                end
                BUSY_WAIT: begin
                    if (last_low) begin
                        state_q <= SHIFT;
                        cnt_q   <= '0;
                        clk_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 9'd1;
                    end
                end
                SHIFT: begin
                    if (last_high) begin
                        // Bits arrive LSB first: shift in from the top.
                        sr_q  <= {trig_s_q, sr_q[TRIG_ID_WIDTH-1:1]};
                        clk_q <= 1'b0;
                        cnt_q <= cnt_q + 9'd1;
                    end else if (last_low) begin
                        if (bit_q == BW'(TRIG_ID_WIDTH - 1)) begin
                            state_q  <= DONE;
                            valid_q  <= 1'b1;
                            id_q     <= sr_q;
                            ts_out_q <= ts_hold_q;
                        end else begin
                            bit_q <= bit_q + BW'(1);
                            cnt_q <= '0;
                            clk_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 9'd1;
                    end
                end
                DONE: begin
                    state_q <= HOLD;
                end
                HOLD: begin
                    if (DUT_READY && !trig_s_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    clk_q   <= 1'b0;
                end
            endcase
            if (rst_edge)
                id_cnt_q <= '0;
        end
    end

    assign TLU_BUSY       = busy_q;
    assign TLU_CLOCK      = clk_q;
    assign TRIG_ID        = id_q;
    assign TRIG_TIMESTAMP = ts_out_q;
    assign TRIG_VALID     = valid_q;
    assign RESET_PULSE    = reset_pulse_q;
    assign SKIP_CNT       = skip_q;

endmodule
